// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchroniser, start-bit qualification, centre sampling on os_tick.
// Define UART_RX_PARITY_EN to expect one even-parity bit between payload and stop bit.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 sample;

    // A bit centre is reached on the last os_tick of a full bit period.
    assign sample    = os_tick && (tick_cnt == FULL_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (os_tick && state != IDLE && state != BREAK)
                tick_cnt <= (sample || (state == START && tick_cnt == HALF_LAST)) ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                START: begin
                    // Re-check the line at mid start bit so short glitches are rejected.
                    if (os_tick && tick_cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_bad <= (^shreg) ^ rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, glitches, breaks and randomized traffic.
// Byte-level model: a frame with a good stop (and parity) queues its payload, anything else queues nothing.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;
    logic [2:0] dbg_state;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .os_tick    (os_tick),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .dbg_state  (dbg_state)
    );

    // clock/reset block: 10 ns clock, os_tick every 4 clocks
    always #5 clk = ~clk;
    logic [1:0] os_div = 2'd0;
    always @(negedge clk) begin
        os_div  = os_div + 2'd1;
        os_tick = (os_div == 2'd3);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];
    int valid_cnt = 0, fe_cnt = 0, pe_cnt = 0;
    int exp_valid = 0, exp_fe = 0, exp_pe = 0;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("unexpected_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (rx_valid && frame_err) check("valid_ferr_exclusive", 32'd1, 32'd0);
        end
    end

    // driver tasks
    task automatic drive_bit(input logic val, input int nclks);
        rx_in = val;
        repeat (nclks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip_par, input int bclk);
        logic bad;
        bad = !stop;
`ifdef UART_RX_PARITY_EN
        bad = bad || flip_par;
`endif
        if (!bad) begin
            exp_q.push_back(d);
            exp_valid++;
            last_good = d;
        end
        if (!stop) exp_fe++;
`ifdef UART_RX_PARITY_EN
        if (flip_par) exp_pe++;
`endif
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ flip_par, bclk);
`endif
        drive_bit(stop, bclk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (rx_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        int busy_seen;
        int v0;
        // reset
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        busy_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_busy !== 1'b0 || rx_valid !== 1'b0) busy_seen++;
        end
        check("idle_200_quiet", busy_seen, 32'd0);

        // single frame
        @(negedge clk);
        send_frame(8'hA5, 1'b1, 1'b0, 64);
        drive_bit(1'b1, 40);
        wait_idle("busy_after_a5");
        check("valid_cnt_a5", valid_cnt, 32'd1);
        check("hold_a5", {24'd0, rx_data}, 32'hA5);

        // back-to-back
        send_frame(8'h00, 1'b1, 1'b0, 64);
        send_frame(8'hFF, 1'b1, 1'b0, 64);
        send_frame(8'h3C, 1'b1, 1'b0, 64);
        drive_bit(1'b1, 40);
        wait_idle("busy_after_b2b");
        check("valid_cnt_b2b", valid_cnt, 32'd4);

        // glitch shorter than half a bit
        v0 = valid_cnt;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 100);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);
        check("glitch_no_valid", valid_cnt, v0);

        // bad stop bit followed by a held break
        send_frame(8'h77, 1'b0, 1'b0, 64);
        drive_bit(1'b0, 300);
        check("break_ferr_once", fe_cnt, 32'd1);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        check("break_data_kept", {24'd0, rx_data}, 32'h3C);
        check("break_no_valid", valid_cnt, 32'd4);
        drive_bit(1'b1, 40);
        wait_idle("busy_after_break");
        send_frame(8'hB2, 1'b1, 1'b0, 64);
        drive_bit(1'b1, 40);
        check("after_break_b2", {24'd0, rx_data}, 32'hB2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1, 64);
        drive_bit(1'b1, 40);
        check("parity_err_5a", pe_cnt, 32'd1);
        check("parity_data_kept", {24'd0, rx_data}, 32'hB2);
`endif

        // reset mid-frame aborts silently
        v0 = valid_cnt;
        drive_bit(1'b0, 150);
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 700);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check("midrst_no_valid", valid_cnt, v0);
        check("midrst_data_cleared", {24'd0, rx_data}, 32'd0);
        last_good = 8'h00;

        // randomized traffic with +/-3% rate mismatch and occasional bad stop bits
        for (int f = 0; f < 24; f++) begin
            logic [7:0] d;
            logic stop;
            int bclk;
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: bclk = 62;
                1: bclk = 64;
                default: bclk = 66;
            endcase
            send_frame(d, stop, 1'b0, bclk);
            if (!stop) begin
                drive_bit(1'b0, $urandom_range(0, 100));
                drive_bit(1'b1, 40);
                wait_idle("rand_break_recover");
                check("rand_break_data_kept", {24'd0, rx_data}, {24'd0, last_good});
            end
            drive_bit(1'b1, $urandom_range(0, 40));
        end
        drive_bit(1'b1, 60);
        wait_idle("busy_end");

        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_valid_cnt", valid_cnt, exp_valid);
        check("final_ferr_cnt", fe_cnt, exp_fe);
        check("final_perr_cnt", pe_cnt, exp_pe);
        check("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
